// File: rtl/glitch_trigger_if.sv
// Control/status bundle between the glitch controller (master side) and
// glitch_trigger (slave side): target reset input, arm/abort commands,
// sequence timing values and the glitch/status outputs.
interface glitch_trigger_if #(
  parameter int DELAY_W = 32,
  parameter int WIDTH_W = 16
);
  logic               target_reset_n;
  logic               arm;
  logic               abort;
  logic [DELAY_W-1:0] delay;
  logic [WIDTH_W-1:0] width;
  logic               glitch_out;
  logic               busy;
  logic               done;

  modport master (
    output target_reset_n, arm, abort, delay, width,
    input  glitch_out, busy, done
  );

  modport slave (
    input  target_reset_n, arm, abort, delay, width,
    output glitch_out, busy, done
  );
endinterface

// File: rtl/glitch_trigger.sv
// glitch_trigger: after an arm command, waits for the target reset release
// (rising edge of target_reset_n), counts a programmable delay, then drives
// one glitch pulse of programmable width and reports completion on done.
// Optional feature macro: GLITCH_AUTOREARM_EN -- when defined, a finished
// sequence returns to ARMED (busy held high) so every later reset release
// repeats the glitch with the latched delay/width until abort or rst_n.
module glitch_trigger #(
  parameter int DELAY_W = 32,
  parameter int WIDTH_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  glitch_trigger_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rst_q;
  logic [DELAY_W-1:0] dly_lat_q, dly_lat_d;
  logic [WIDTH_W-1:0] wid_lat_q, wid_lat_d;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [WIDTH_W-1:0] wid_cnt_q, wid_cnt_d;
  logic               glitch_q, glitch_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               rel_edge;

  // Saturating decrement: counters stop at zero and never wrap.
  function automatic logic [DELAY_W-1:0] dec_dly(input logic [DELAY_W-1:0] v);
    return (v == '0) ? v : v - DELAY_W'(1);
  endfunction

  function automatic logic [WIDTH_W-1:0] dec_wid(input logic [WIDTH_W-1:0] v);
    return (v == '0) ? v : v - WIDTH_W'(1);
  endfunction

  // Release edge: line high now, was low at the previous edge.
  assign rel_edge = bus.target_reset_n & ~rst_q;

  // Next-state, counter and output decode; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    dly_lat_d = dly_lat_q;
    wid_lat_d = wid_lat_q;
    dly_cnt_d = dly_cnt_q;
    wid_cnt_d = wid_cnt_q;
    glitch_d  = glitch_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    if (bus.abort) begin
      state_d  = S_IDLE;
      glitch_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          glitch_d = 1'b0;
          if (bus.arm) begin
            dly_lat_d = bus.delay;
            wid_lat_d = bus.width;
            state_d   = S_ARMED;
          end
        end
        S_ARMED: begin
          glitch_d = 1'b0;
          if (rel_edge) begin
            dly_cnt_d = dly_lat_q;
            state_d   = S_DELAY;
          end
        end
        S_DELAY: begin
          if (!bus.target_reset_n) begin
            // Target went back into reset: wait for the next release.
            glitch_d = 1'b0;
            state_d  = S_ARMED;
          end else if (dly_cnt_q == '0) begin
            if (wid_lat_q != '0) begin
              glitch_d  = 1'b1;
              wid_cnt_d = wid_lat_q - WIDTH_W'(1);
              state_d   = S_PULSE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            dly_cnt_d = dec_dly(dly_cnt_q);
          end
        end
        S_PULSE: begin
          if (!bus.target_reset_n) begin
            glitch_d = 1'b0;
            state_d  = S_ARMED;
          end else if (wid_cnt_q == '0) begin
            glitch_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            wid_cnt_d = dec_wid(wid_cnt_q);
          end
        end
        S_DONE: begin
          glitch_d = 1'b0;
          done_d   = 1'b1;
`ifdef GLITCH_AUTOREARM_EN
          state_d  = S_ARMED;
`else
          state_d  = S_IDLE;
`endif
        end
        default: begin
          glitch_d = 1'b0;
          state_d  = S_IDLE;
        end
      endcase
    end

    // busy is registered so it lines up with the state it describes.
`ifdef GLITCH_AUTOREARM_EN
    busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) ||
             (state_d == S_PULSE) || (state_d == S_DONE);
`else
    busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) ||
             (state_d == S_PULSE);
`endif
  end

  // State, counters and registered outputs; rst_q resets high so no false release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rst_q     <= 1'b1;
      dly_lat_q <= '0;
      wid_lat_q <= '0;
      dly_cnt_q <= '0;
      wid_cnt_q <= '0;
      glitch_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_q     <= bus.target_reset_n;
      dly_lat_q <= dly_lat_d;
      wid_lat_q <= wid_lat_d;
      dly_cnt_q <= dly_cnt_d;
      wid_cnt_q <= wid_cnt_d;
      glitch_q  <= glitch_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.glitch_out = glitch_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule
